// File: rtl/reg_file_xp.sv
// Multi-port register file: two combinational read ports, one byte-enabled
// write port, optional hardwired-zero register 0, and a sequenced bulk clear.
module reg_file_xp #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_req,
  output logic               busy,
  input  logic               we,
  input  logic [WIDTH/8-1:0] be,
  input  logic [AW-1:0]      reg_w,
  input  logic [WIDTH-1:0]   bus_w,
  input  logic [AW-1:0]      reg_a,
  input  logic [AW-1:0]      reg_b,
  output logic [WIDTH-1:0]   bus_a,
  output logic [WIDTH-1:0]   bus_b,
  output logic               wr_drop
);

  localparam int DEPTH = 1 << AW;
  localparam int NB    = WIDTH / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_next;
  logic [AW-1:0]     ptr, ptr_next;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  wmask;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_en;
  logic              zero_w;

  assign busy   = (state == CLEAR);
  assign zero_w = (ZERO_REG != 0) && (reg_w == '0);
  // A write commits only in IDLE outside reset; the same qualifier gates forwarding.
  assign wr_en  = !rst && !busy && we && (be != '0) && !zero_w;

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wmask[8*i +: 8] = {8{be[i]}};
    end
  end

  assign wr_data = (mem[reg_w] & ~wmask) | (bus_w & wmask);

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        ptr_next = ptr + 1'b1;
        if (ptr == '1) state_next = IDLE;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      ptr     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      wr_drop <= busy && we && (be != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[ptr] <= '0;
      end else if (wr_en) begin
        mem[reg_w] <= wr_data;
      end
    end
  end

  always_comb begin
    bus_a = '0;
    if (!busy && !((ZERO_REG != 0) && (reg_a == '0))) begin
      if ((BYPASS != 0) && wr_en && (reg_w == reg_a)) bus_a = (mem[reg_a] & ~wmask) | (bus_w & wmask);
      else                                            bus_a = mem[reg_a];
    end
  end

  always_comb begin
    bus_b = '0;
    if (!busy && !((ZERO_REG != 0) && (reg_b == '0))) begin
      if ((BYPASS != 0) && wr_en && (reg_w == reg_b)) bus_b = (mem[reg_b] & ~wmask) | (bus_w & wmask);
      else                                            bus_b = mem[reg_b];
    end
  end

endmodule
